// File: rtl/add8u_pkg.sv
// ---------------------------------------------------------------------------
// Package: add8u_pkg
// Shared widths, operand/statistics types and a small helper for the
// approximate 8-bit adder slice (add8u_approx_core, add8u_shared_arbiter).
// Contents:
//   OP_W          operand width (8)
//   SUM_W         result width, carry included (9)
//   ERR_CNT_W     error-monitor mismatch counter width (16)
//   APPROX_LO_W   number of low bits computed with OR instead of add (2)
//   add8u_op_t    operand pair held in the operand stage
//   add8u_err_t   error-monitor statistics pair
//   abs_diff()    |x - y| on SUM_W-bit values
// ---------------------------------------------------------------------------
package add8u_pkg;

  localparam int OP_W        = 8;
  localparam int SUM_W       = 9;
  localparam int ERR_CNT_W   = 16;
  localparam int APPROX_LO_W = 2;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } add8u_op_t;

  typedef struct packed {
    logic [ERR_CNT_W-1:0] cnt;
    logic [SUM_W-1:0]     max;
  } add8u_err_t;

  // Magnitude of the distance between two sums, never negative.
  function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] x,
                                                input logic [SUM_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/add8u_approx_core.sv
// ---------------------------------------------------------------------------
// Module: add8u_approx_core
// Purely combinational lower-part-OR approximate adder.
//   The low APPROX_LO_W bits are produced by OR-ing the operands; the carry
//   into the upper part is predicted from the top bit of the low part
//   (a[1] & b[1]) instead of being propagated. The upper part is an exact add.
// Ports:
//   a    in   OP_W    operand A
//   b    in   OP_W    operand B
//   sum  out  SUM_W   approximate sum {carry, sum[7:0]}
// ---------------------------------------------------------------------------
module add8u_approx_core
  import add8u_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [SUM_W-1:0] sum
);

  localparam int HI_W = OP_W - APPROX_LO_W;

  logic            carry_pred;
  logic [HI_W:0]   hi_sum;

  // Predicting the carry from the MSBs of the low part keeps the carry chain
  // out of the low bits; when both are set a carry is certain, otherwise it
  // is assumed absent.
  assign carry_pred = a[APPROX_LO_W-1] & b[APPROX_LO_W-1];

  assign hi_sum = {1'b0, a[OP_W-1:APPROX_LO_W]}
                + {1'b0, b[OP_W-1:APPROX_LO_W]}
                + {{HI_W{1'b0}}, carry_pred};

  assign sum = {hi_sum, a[APPROX_LO_W-1:0] | b[APPROX_LO_W-1:0]};

endmodule

// File: rtl/add8u_shared_arbiter.sv
// ---------------------------------------------------------------------------
// Module: add8u_shared_arbiter
// Shares one add8u_approx_core among N_REQ requesters. Round-robin grant on
// per-requester valid/ready, then a two-stage pipeline (operand register,
// result register). Results carry the ID of the issuing requester.
// Throughput 1 op/clk; an accept in cycle T shows rsp_valid in cycle T+2.
// Parameters:
//   N_REQ   number of requesters (2..8)
//   IDW     ID width, $clog2(N_REQ)
// Ports:
//   clk        in   1           clock, rising edge
//   rst_n      in   1           synchronous active-low reset
//   req_valid  in   N_REQ       per-requester operand valid
//   req_ready  out  N_REQ       per-requester accept, one-hot or zero
//   req_a      in   8*N_REQ     operand A, requester i at [8i+7:8i]
//   req_b      in   8*N_REQ     operand B, same packing
//   rsp_valid  out  1           result valid
//   rsp_ready  in   1           consumer accept
//   rsp_sum    out  9           approximate sum
//   rsp_id     out  IDW         requester that issued the result
//   err_clr    in   1           clear error statistics     (ADD8U_ERR_MON_EN)
//   err_cnt    out  16          saturating mismatch count  (ADD8U_ERR_MON_EN)
//   err_max    out  9           max |exact - approx| seen  (ADD8U_ERR_MON_EN)
// Configuration macro:
//   ADD8U_ERR_MON_EN  adds an exact adder on the operand stage and the
//                     err_* statistics; the datapath is identical either way.
// ---------------------------------------------------------------------------
module add8u_shared_arbiter
  import add8u_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SUM_W-1:0]      rsp_sum,
  output logic [IDW-1:0]        rsp_id
`ifdef ADD8U_ERR_MON_EN
  ,
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]      err_max
`endif
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_any;
  logic             adv;
  logic             s1_take;
  logic             xfer;
  logic             s1_valid;
  add8u_op_t        s1_op;
  logic [IDW-1:0]   s1_id;
  logic [SUM_W-1:0] core_sum;

  // Increment modulo N_REQ, valid for non-power-of-two requester counts.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    if (int'(v) == N_REQ - 1) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // The output stage can take a new value when it is empty or being drained;
  // the operand stage can take one when it is empty or moving forward.
  assign adv     = !rsp_valid || rsp_ready;
  assign s1_take = !s1_valid || adv;

  // Round-robin search: start at ptr, wrap, first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // rst_n gates the grant so nothing is offered while reset is asserted,
  // even before the registers have been cleared.
  assign xfer = rst_n && s1_take && grant_any;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operand stage and round-robin pointer. The pointer only moves past a
  // requester that actually transferred, so idle cycles keep fairness intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
    end else if (xfer) begin
      ptr      <= wrap_inc(grant_idx);
      s1_valid <= 1'b1;
      s1_op.a  <= req_a[grant_idx*OP_W +: OP_W];
      s1_op.b  <= req_b[grant_idx*OP_W +: OP_W];
      s1_id    <= grant_idx;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  add8u_approx_core u_core (
    .a   (s1_op.a),
    .b   (s1_op.b),
    .sum (core_sum)
  );

  // Result stage. Under backpressure (rsp_valid & !rsp_ready) adv is low and
  // sum/id hold; when the operand stage is empty the result simply empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else if (adv) begin
      if (s1_valid) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= core_sum;
        rsp_id    <= s1_id;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ADD8U_ERR_MON_EN
  logic [SUM_W-1:0] exact_sum;
  logic [SUM_W-1:0] err_dist;
  add8u_err_t       err_q;

  assign exact_sum = {1'b0, s1_op.a} + {1'b0, s1_op.b};
  assign err_dist  = abs_diff(exact_sum, core_sum);

  // Statistics sample the same event that loads the result register, so each
  // operation is counted exactly once. err_clr beats a same-cycle update.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_q <= '0;
    end else if (adv && s1_valid && (exact_sum != core_sum)) begin
      if (err_q.cnt != {ERR_CNT_W{1'b1}}) begin
        err_q.cnt <= err_q.cnt + 1'b1;
      end
      if (err_dist > err_q.max) begin
        err_q.max <= err_dist;
      end
    end
  end

  assign err_cnt = err_q.cnt;
  assign err_max = err_q.max;
`endif

endmodule

// File: tb/tb_add8u_shared_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench: tb_add8u_shared_arbiter
// Directed scenarios (reset, round-robin order, single op latency,
// backpressure, approximation, mid-op reset) followed by random traffic.
// A monitor on the falling edge predicts req_ready and every response from
// an arithmetic model of the approximate adder and a queue of accepted ops.
// Macro ADD8U_ERR_MON_EN enables the error-statistics checks.
// ---------------------------------------------------------------------------
module tb_add8u_shared_arbiter;

  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [8*N_REQ-1:0]   req_a;
  logic [8*N_REQ-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [8:0]           rsp_sum;
  logic [IDW-1:0]       rsp_id;
`ifdef ADD8U_ERR_MON_EN
  logic                 err_clr;
  logic [15:0]          err_cnt;
  logic [8:0]           err_max;
  int                   model_err_cnt;
  int                   model_err_max;
`endif

  typedef struct {
    int a;
    int b;
    int id;
    int acc_cyc;
  } op_t;

  op_t              pend[$];
  int               acc_id[$];
  int               acc_cyc_q[$];
  int               exp_ptr;
  int               cyc = 0;
  int               delivered = 0;
  int               vectors = 0;
  int               miscompares = 0;
  bit               rst_q = 1'b1;
  logic [N_REQ-1:0] taken = '0;

  add8u_shared_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADD8U_ERR_MON_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
    .err_max   (err_max)
`endif
  );

  always #5 clk = ~clk;

  // Approximate sum from the adder's rules: OR of the two low bits, exact
  // add of the upper six bits plus a carry assumed only when a[1] and b[1].
  function automatic int approx_sum(input int a, input int b);
    int hi;
    hi = (a / 4) + (b / 4) + (((a / 2) % 2) * ((b / 2) % 2));
    return hi * 4 + ((a | b) & 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic new_ops(input int k);
    req_a[8*k +: 8] = rand_byte();
    req_b[8*k +: 8] = rand_byte();
  endtask

  // Requesters accepted at the last edge either get fresh operands (keep=1)
  // or drop their valid.
  task automatic refresh_taken(input logic [N_REQ-1:0] keep);
    for (int k = 0; k < N_REQ; k++) begin
      if (taken[k]) begin
        if (keep[k]) new_ops(k);
        else req_valid[k] = 1'b0;
      end
    end
  endtask

  // One random cycle: legal requester behaviour (hold operands until
  // accepted, occasional drop of valid) and random consumer backpressure.
  task automatic applyStimulus();
    for (int k = 0; k < N_REQ; k++) begin
      if (taken[k] || !req_valid[k]) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        if (req_valid[k]) new_ops(k);
      end else if ($urandom_range(0, 9) == 0) begin
        req_valid[k] = 1'b0;
      end
    end
    rsp_ready = ($urandom_range(0, 9) < 7);
    tick();
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while ((pend.size() != 0 || rsp_valid) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) checkOutput("drain_timeout", pend.size(), 0);
  endtask

  task automatic single_op(input int k, input logic [7:0] a, input logic [7:0] b,
                           input int exp_sum, input string tag);
    int n;
    int lat;
    acc_id.delete();
    acc_cyc_q.delete();
    req_valid = '0;
    req_valid[k] = 1'b1;
    req_a[8*k +: 8] = a;
    req_b[8*k +: 8] = b;
    rsp_ready = 1'b1;
    n = 0;
    while (acc_id.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    req_valid = '0;
    checkOutput({tag, "_accepted"}, acc_id.size(), 1);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = (acc_cyc_q.size() > 0) ? (cyc - acc_cyc_q[0]) : -1;
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1);
    checkOutput({tag, "_latency"}, lat, 2);
    checkOutput({tag, "_sum"}, rsp_sum, exp_sum);
    checkOutput({tag, "_id"}, rsp_id, k);
    tick();
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Falling-edge monitor: predicts the grant and checks each response
  // against the queue of accepted operations.
  always @(negedge clk) begin : monitor
    op_t              e;
    logic [N_REQ-1:0] exp_ready;
    bit               found;
    bit               blocked;
    int               g;
    taken = '0;
    if (!rst_n) begin
      checkOutput("reset_req_ready", req_ready, 0);
      if (!rst_q) checkOutput("reset_rsp_valid", rsp_valid, 0);
      pend.delete();
      exp_ptr = 0;
`ifdef ADD8U_ERR_MON_EN
      model_err_cnt = 0;
      model_err_max = 0;
`endif
    end else begin
      blocked   = (pend.size() >= 2) && !rsp_ready;
      exp_ready = '0;
      found     = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        g = (exp_ptr + k) % N_REQ;
        if (!blocked && !found && req_valid[g]) begin
          exp_ready[g] = 1'b1;
          found = 1'b1;
        end
      end
      checkOutput("req_ready", req_ready, exp_ready);
      if (rsp_valid) begin
        if (pend.size() == 0) begin
          checkOutput("rsp_unexpected", rsp_valid, 0);
        end else begin
          checkOutput("rsp_sum", rsp_sum, approx_sum(pend[0].a, pend[0].b));
          checkOutput("rsp_id", rsp_id, pend[0].id);
          checkOutput("rsp_latency_ge2", (cyc - pend[0].acc_cyc) >= 2, 1);
          if (rsp_ready) begin
`ifdef ADD8U_ERR_MON_EN
            begin
              int ex;
              int ap;
              int d;
              ex = pend[0].a + pend[0].b;
              ap = approx_sum(pend[0].a, pend[0].b);
              d  = (ex > ap) ? ex - ap : ap - ex;
              if (d != 0) begin
                if (model_err_cnt < 65535) model_err_cnt++;
                if (d > model_err_max) model_err_max = d;
              end
            end
`endif
            void'(pend.pop_front());
            delivered++;
          end
        end
      end
`ifdef ADD8U_ERR_MON_EN
      if (err_clr) begin
        model_err_cnt = 0;
        model_err_max = 0;
      end
`endif
      taken = req_valid & req_ready;
      for (int k = 0; k < N_REQ; k++) begin
        if (taken[k]) begin
          e.a       = int'(req_a[8*k +: 8]);
          e.b       = int'(req_b[8*k +: 8]);
          e.id      = k;
          e.acc_cyc = cyc;
          pend.push_back(e);
          acc_id.push_back(k);
          acc_cyc_q.push_back(cyc);
          exp_ptr = (k + 1) % N_REQ;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    logic [8:0]     held_sum;
    logic [IDW-1:0] held_id;

    // Reset held for three clocks with every requester asking.
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
`ifdef ADD8U_ERR_MON_EN
    err_clr   = 1'b0;
`endif
    for (int k = 0; k < N_REQ; k++) new_ops(k);
    repeat (3) tick();
    acc_id.delete();
    acc_cyc_q.delete();
    rst_n = 1'b1;

    // Round-robin with all four continuously valid.
    n = 0;
    while (acc_id.size() < 6 && n < 30) begin
      refresh_taken('1);
      tick();
      n++;
    end
    req_valid = '0;
    checkOutput("rr_accepts", acc_id.size() >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      if (k < acc_id.size()) begin
        checkOutput("rr_order", acc_id[k], k % N_REQ);
        checkOutput("rr_one_per_clk", acc_cyc_q[k], acc_cyc_q[0] + k);
      end
    end
    drain();

    // Single exact-looking op.
    single_op(0, 8'd200, 8'd100, 300, "single");
    drain();

    // Backpressure: three queued ops, consumer stalled for five clocks.
    base      = delivered;
    rsp_ready = 1'b0;
    req_valid = 4'b1110;
    for (int k = 1; k < N_REQ; k++) new_ops(k);
    held_sum = '0;
    held_id  = '0;
    for (int k = 0; k < 5; k++) begin
      refresh_taken('0);
      tick();
      if (k == 2) begin
        held_sum = rsp_sum;
        held_id  = rsp_id;
      end
    end
    checkOutput("bp_rsp_valid", rsp_valid, 1);
    checkOutput("bp_req_ready_blocked", req_ready, 0);
    checkOutput("bp_sum_hold", rsp_sum, held_sum);
    checkOutput("bp_id_hold", rsp_id, held_id);
    rsp_ready = 1'b1;
    n = 0;
    while ((delivered - base) < 3 && n < 20) begin
      refresh_taken('0);
      tick();
      n++;
    end
    req_valid = '0;
    drain();
    checkOutput("bp_delivered", delivered - base, 3);

    // Approximation: 3 + 1 yields 3 from this adder.
`ifdef ADD8U_ERR_MON_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
`endif
    single_op(0, 8'd3, 8'd1, 3, "approx");
    drain();
`ifdef ADD8U_ERR_MON_EN
    checkOutput("err_cnt", err_cnt, 1);
    checkOutput("err_max", err_max, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_cnt_clr", err_cnt, 0);
    checkOutput("err_max_clr", err_max, 0);
`endif

    // Mid-operation reset: accept from requester 2, reset one clock later.
    acc_id.delete();
    acc_cyc_q.delete();
    req_valid = 4'b0100;
    new_ops(2);
    n = 0;
    while (acc_id.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("midrst_accept_id", (acc_id.size() > 0) ? acc_id[0] : -1, 2);
    rst_n     = 1'b0;
    req_valid = '1;
    for (int k = 0; k < N_REQ; k++) new_ops(k);
    repeat (2) tick();
    acc_id.delete();
    acc_cyc_q.delete();
    rst_n = 1'b1;
    checkOutput("midrst_no_rsp", rsp_valid, 0);
    n = 0;
    while (acc_id.size() == 0 && n < 10) begin
      refresh_taken('1);
      tick();
      n++;
    end
    req_valid = '0;
    checkOutput("midrst_first_grant", (acc_id.size() > 0) ? acc_id[0] : -1, 0);
    drain();

    // Random traffic.
`ifdef ADD8U_ERR_MON_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
`endif
    repeat (400) applyStimulus();
    req_valid = '0;
    drain();
`ifdef ADD8U_ERR_MON_EN
    checkOutput("rand_err_cnt", err_cnt, model_err_cnt);
    checkOutput("rand_err_max", err_max, model_err_max);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
